// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: the hazard FSM state encoding and the
// operand-forwarding select codes used by the EX stage.
package PipelineReg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } HazState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one ALU operand: selects the youngest in-flight
// producer of the source register (MEM before WB). x0 is never forwarded.
module fwd_sel
  import PipelineReg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs);
  assign wb_hit  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)
      sel = FWD_MEM;
    else if (wb_hit)
      sel = FWD_WB;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: load-use stalls, redirect flushes, data-memory
// wait, operand forwarding selects and saturating debug counters.
module ex_hazard_ctrl
  import PipelineReg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_ex_jmp,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_regwrite,
  input  logic             i_mem_busy,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_id_ex_stall,
  output logic             o_ex_mem_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  HazState_t  state_q;
  HazState_t  state_d;
  logic       lu;
  logic       jmp;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  assign lu = i_ex_memread && (i_ex_rd != 5'd0) &&
              ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
               (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

  // EX holds a bubble while in FLUSH, so a redirect seen there is stale.
  assign jmp = i_ex_jmp && (state_q != FLUSH);

  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    state_d        = RUN;
    if (i_reset) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if (i_mem_busy) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
      state_d        = MEM_WAIT;
    end else if (jmp) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      state_d        = FLUSH;
    end else if (lu) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_bubble = 1'b1;
      state_d        = LU_STALL;
    end
  end

  fwd_sel u_fwd_a (
    .rs           (i_ex_rs1),
    .mem_rd       (i_mem_rd),
    .mem_regwrite (i_mem_regwrite),
    .wb_rd        (i_wb_rd),
    .wb_regwrite  (i_wb_regwrite),
    .sel          (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .rs           (i_ex_rs2),
    .mem_rd       (i_mem_rd),
    .mem_regwrite (i_mem_regwrite),
    .wb_rd        (i_wb_rd),
    .wb_regwrite  (i_wb_regwrite),
    .sel          (fwd_b_raw)
  );

  assign o_fwd_a = i_reset ? FWD_RF : fwd_a_raw;
  assign o_fwd_b = i_reset ? FWD_RF : fwd_b_raw;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= RUN;
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      state_q <= state_d;
      if (o_pc_stall && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + 1'b1;
      if (o_if_id_flush && (o_flush_count != '1))
        o_flush_count <= o_flush_count + 1'b1;
    end
  end

  assign o_state = state_q;

endmodule
